cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the single-issue RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back around the instruction decoder and ALU datapath. It handshakes with instruction and data memory, generates the IR/PC/register-file write strobes, counts retired instructions, and traps to a sticky error state on a memory-ack timeout.

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control FSM for the single-issue RV32I core. Each instruction
// walks IF -> ID -> EX -> [MEM] -> WB. The FSM handshakes with instruction and
// data memory, produces the IR/PC/register-file write strobes, counts retired
// instructions, and traps to a sticky ERR state when a memory ack times out.
//
// Parameters:
//   TIMEOUT   max wait cycles for a memory ack before ERR (1..255)
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   imem_ack, dmem_ack         memory handshakes
//   is_load, is_store, reg_we,
//   is_halt, is_jump, br_taken decoder / branch-comparator flags
//   imem_req, dmem_req, dmem_we memory requests (combinational)
//   ir_we, pc_we, pc_sel, rf_we datapath strobes (combinational)
//   halted, error              registered status flags
//   state                      current state encoding (debug)
//   instret                    retired-instruction count
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_we,
    input  logic        is_halt,
    input  logic        is_jump,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        halted,
    output logic        error,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] instret_q, instret_d;
    logic        halted_q, halted_d;
    logic        error_q, error_d;

    // Next-state, wait counter and retire counter.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        case (state_q)
            S_IF: begin
                // An ack on the same cycle the counter hits TIMEOUT still wins.
                if (imem_ack) begin
                    state_d = S_ID;
                end else if (wait_q == TIMEOUT_C) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_ID: begin
                state_d = is_halt ? S_HALT : S_EX;
            end
            S_EX: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_store) begin
                        // Stores retire straight from MEM; no WB cycle.
                        state_d   = S_IF;
                        wait_d    = 8'd0;
                        instret_d = instret_q + 32'd1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TIMEOUT_C) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d   = S_IF;
                wait_d    = 8'd0;
                instret_d = instret_q + 32'd1;
            end
            S_HALT: state_d = S_HALT;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_ERR;   // illegal encoding 7
        endcase
        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            wait_q    <= 8'd0;
            instret_q <= 32'd0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
            error_q   <= error_d;
        end
    end

    // Strobes are combinational decodes of the state and live inputs; they
    // are forced low while reset is held so nothing fires before release.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = dmem_ack & is_store;
                end
                S_WB: begin
                    rf_we  = reg_we;
                    pc_we  = 1'b1;
                    pc_sel = br_taken | is_jump;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign halted  = halted_q;
    assign error   = error_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed-vector bench. A driver applies per-cycle inputs just after each
// rising edge and queues the hand-computed expected state, strobes and
// instret for that cycle; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    typedef struct packed {
        logic [2:0]  st;
        logic [8:0]  fl;   // {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,rf_we,halted,error}
        logic [31:0] ir;
    } exp_t;

    // Input bits {imem_ack,dmem_ack,is_load,is_store,reg_we,is_halt,is_jump,br_taken}
    localparam logic [7:0] IA = 8'h80, DA = 8'h40, LD = 8'h20, SW = 8'h10;
    localparam logic [7:0] RW = 8'h08, HL = 8'h04, JP = 8'h02, BT = 8'h01;

    localparam logic [8:0] IREQ = 9'h100, DREQ = 9'h080, DWE = 9'h040, IRWE = 9'h020;
    localparam logic [8:0] PCWE = 9'h010, PCSEL = 9'h008, RFWE = 9'h004;
    localparam logic [8:0] HLT = 9'h002, ERRF = 9'h001, NONE = 9'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic        reg_we = 1'b0, is_halt = 1'b0, is_jump = 1'b0, br_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, halted, error;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fails  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cpu_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_load(is_load), .is_store(is_store), .reg_we(reg_we),
        .is_halt(is_halt), .is_jump(is_jump), .br_taken(br_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .halted(halted), .error(error), .state(state), .instret(instret)
    );

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] fl;
            e  = exp_q.pop_front();
            fl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, halted, error};
            n_checks++;
            if (state !== e.st) begin
                n_fails++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
            end
            n_checks++;
            if (fl !== e.fl) begin
                n_fails++;
                $display("FAIL strobes @%0t: got %b expected %b", $time, fl, e.fl);
            end
            n_checks++;
            if (instret !== e.ir) begin
                n_fails++;
                $display("FAIL instret @%0t: got %0d expected %0d", $time, instret, e.ir);
            end
        end
    end

    // One clock cycle: apply reset level and inputs, queue what must be seen.
    task automatic cyc(input logic r, input logic [7:0] in,
                       input logic [2:0] s, input logic [8:0] f, input logic [31:0] n);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        {imem_ack, dmem_ack, is_load, is_store, reg_we, is_halt, is_jump, br_taken} = in;
        e.st = s;
        e.fl = f;
        e.ir = n;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset held with a stray ack: nothing may fire.
        cyc(1'b0, IA | DA, 3'd0, NONE, 0);
        // ADDI: IF(ack) ID EX WB
        cyc(1'b1, IA | RW, 3'd0, IREQ | IRWE, 0);
        cyc(1'b1, RW,      3'd1, NONE, 0);
        cyc(1'b1, RW,      3'd2, NONE, 0);
        cyc(1'b1, RW,      3'd4, RFWE | PCWE, 0);
        // LW, dmem ack on the 4th MEM cycle
        cyc(1'b1, IA | LD | RW, 3'd0, IREQ | IRWE, 1);
        cyc(1'b1, LD | RW,      3'd1, NONE, 1);
        cyc(1'b1, LD | RW,      3'd2, NONE, 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, LD | RW, 3'd3, DREQ, 1);
        cyc(1'b1, DA | LD | RW, 3'd3, DREQ, 1);
        cyc(1'b1, LD | RW,      3'd4, RFWE | PCWE, 1);
        // SW (reg_we asserted to show it cannot leak into rf_we)
        cyc(1'b1, IA | SW | RW, 3'd0, IREQ | IRWE, 2);
        cyc(1'b1, SW | RW,      3'd1, NONE, 2);
        cyc(1'b1, SW | RW,      3'd2, NONE, 2);
        cyc(1'b1, DA | SW | RW, 3'd3, DREQ | DWE | PCWE, 2);
        // BEQ taken, with stray acks outside their states
        cyc(1'b1, IA,           3'd0, IREQ | IRWE, 3);
        cyc(1'b1, IA | DA | BT, 3'd1, NONE, 3);
        cyc(1'b1, IA | DA | BT, 3'd2, NONE, 3);
        cyc(1'b1, IA | DA | BT, 3'd4, PCWE | PCSEL, 3);
        // JAL, br_taken low
        cyc(1'b1, IA | JP | RW, 3'd0, IREQ | IRWE, 4);
        cyc(1'b1, JP | RW,      3'd1, NONE, 4);
        cyc(1'b1, JP | RW,      3'd2, NONE, 4);
        cyc(1'b1, JP | RW,      3'd4, PCWE | PCSEL | RFWE, 4);
        // Fetch acked on the 5th IF cycle (counter == TIMEOUT): ack wins
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h00, 3'd0, IREQ, 5);
        cyc(1'b1, IA | RW, 3'd0, IREQ | IRWE, 5);
        cyc(1'b1, RW,      3'd1, NONE, 5);
        cyc(1'b1, RW,      3'd2, NONE, 5);
        cyc(1'b1, RW,      3'd4, RFWE | PCWE, 5);
        // Halt: not counted, sticky, ignores everything
        cyc(1'b1, IA | HL, 3'd0, IREQ | IRWE, 6);
        cyc(1'b1, HL,      3'd1, NONE, 6);
        for (int i = 0; i < 100; i++) cyc(1'b1, IA | DA | HL | RW | BT, 3'd5, HLT, 6);
        // Reset dropped just after an edge: state and instret clear immediately
        cyc(1'b0, 8'h00, 3'd0, NONE, 0);
        // Release, then starve the fetch: ERR after 5 IF cycles
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 3'd0, IREQ, 0);
        for (int i = 0; i < 10; i++) cyc(1'b1, IA | DA | RW | SW, 3'd6, ERRF, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
